// File: rtl/fft_pkg.sv
// Shared FFT constants and width helpers used by the transform wrappers and the
// post-transform peak detector.
package fft_pkg;

    localparam int FFT_STAGE_DEF = 32'd6;
    localparam int FFT_MAX       = 32'd1 << FFT_STAGE_DEF;

    function automatic int pow_w(input int data_width);
        return 32'd2 * data_width;
    endfunction

    function automatic int bin_idx_w(input int fft_stage);
        return fft_stage;
    endfunction

    function automatic int fft_max(input int fft_stage);
        return 32'd1 << fft_stage;
    endfunction

endpackage

// File: rtl/fft_cplx_pow.sv
// Two-stage |X|^2 pipeline: registered signed squares, then their registered sum,
// with valid/sop/eop/index sideband travelling alongside.
module fft_cplx_pow
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 32'd16,
    parameter int IDX_W      = 32'd6
) (
    input  logic                             iclk,
    input  logic                             rstn,
    input  logic                             iclr,
    input  logic [DATA_WIDTH-1:0]            ire,
    input  logic [DATA_WIDTH-1:0]            iim,
    input  logic                             ien,
    input  logic                             isop,
    input  logic                             ieop,
    input  logic [IDX_W-1:0]                 iidx,
    output logic [pow_w(DATA_WIDTH)-1:0]     opow,
    output logic                             oen,
    output logic                             osop,
    output logic                             oeop,
    output logic [IDX_W-1:0]                 oidx
);

    localparam int PW = pow_w(DATA_WIDTH);

    logic signed [PW-1:0] re_ext_s;
    logic signed [PW-1:0] im_ext_s;
    logic [PW-1:0]        sq_re_r;
    logic [PW-1:0]        sq_im_r;
    logic                 v1_r;
    logic                 sop1_r;
    logic                 eop1_r;
    logic [IDX_W-1:0]     idx1_r;

    assign re_ext_s = {{DATA_WIDTH{ire[DATA_WIDTH-1]}}, ire};
    assign im_ext_s = {{DATA_WIDTH{iim[DATA_WIDTH-1]}}, iim};

    // Stage 1: squares load only on accepted samples; the valid bit follows ien.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            v1_r    <= 1'b0;
            sop1_r  <= 1'b0;
            eop1_r  <= 1'b0;
            idx1_r  <= '0;
            sq_re_r <= '0;
            sq_im_r <= '0;
        end else begin
            v1_r <= ien;
            if (ien) begin
                sop1_r  <= isop;
                eop1_r  <= ieop;
                idx1_r  <= iidx;
                sq_re_r <= re_ext_s * re_ext_s;
                sq_im_r <= im_ext_s * im_ext_s;
            end
        end
    end

    // Stage 2: unsigned sum; a frame restart drops whatever stage 1 was holding.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            oen  <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
            oidx <= '0;
            opow <= '0;
        end else if (iclr) begin
            oen  <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
        end else begin
            oen  <= v1_r;
            osop <= v1_r & sop1_r;
            oeop <= v1_r & eop1_r;
            if (v1_r) begin
                oidx <= idx1_r;
                opow <= sq_re_r + sq_im_r;
            end
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-bin power stream with frame flags, plus strongest-bin tracking reported
// one cycle after each frame's last bin.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 32'd16,
    parameter int FFT_STAGE  = FFT_STAGE_DEF,
    parameter int SKIP_DC    = 32'd1
) (
    input  logic                         iclk,
    input  logic                         rstn,
    input  logic                         iclr,
    input  logic [DATA_WIDTH-1:0]        iReal,
    input  logic [DATA_WIDTH-1:0]        iImag,
    input  logic                         ien,
    output logic [pow_w(DATA_WIDTH)-1:0] oPower,
    output logic                         oen,
    output logic                         osop,
    output logic                         oeop,
    output logic [FFT_STAGE-1:0]         oPeakIdx,
    output logic [pow_w(DATA_WIDTH)-1:0] oPeakPow,
    output logic                         oPeakVld
);

    localparam int                   PW       = pow_w(DATA_WIDTH);
    localparam int                   IW       = bin_idx_w(FFT_STAGE);
    localparam logic [IW-1:0]        LAST_BIN = '1;
    localparam logic [IW-1:0]        ONE_BIN  = IW'(1);

    logic [IW-1:0] cnt_r;
    logic [IW-1:0] idx_in_s;
    logic          sop_in_s;
    logic          eop_in_s;
    logic [IW-1:0] idx2_s;
    logic [PW-1:0] pk_pow_r;
    logic [IW-1:0] pk_idx_r;
    logic [PW-1:0] cand_pow_s;
    logic [IW-1:0] cand_idx_s;

    // A restart makes the sample accepted in the same cycle bin 0 of the new frame.
    always_comb begin
        if (iclr) begin
            idx_in_s = '0;
        end else begin
            idx_in_s = cnt_r;
        end
        sop_in_s = (idx_in_s == '0);
        eop_in_s = (idx_in_s == LAST_BIN);
    end

    // Bin counter advances per accepted sample and wraps naturally at FFT_MAX.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (ien) begin
            cnt_r <= idx_in_s + ONE_BIN;
        end else if (iclr) begin
            cnt_r <= '0;
        end
    end

    fft_cplx_pow #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IW)
    ) u_pow (
        .iclk (iclk),
        .rstn (rstn),
        .iclr (iclr),
        .ire  (iReal),
        .iim  (iImag),
        .ien  (ien),
        .isop (sop_in_s),
        .ieop (eop_in_s),
        .iidx (idx_in_s),
        .opow (oPower),
        .oen  (oen),
        .osop (osop),
        .oeop (oeop),
        .oidx (idx2_s)
    );

    // Next peak: sop reseeds, otherwise only a strictly larger bin wins so ties keep the lower index.
    always_comb begin
        cand_pow_s = pk_pow_r;
        cand_idx_s = pk_idx_r;
        if (oen && osop) begin
            if (SKIP_DC != 32'd0) begin
                cand_pow_s = '0;
                cand_idx_s = ONE_BIN;
            end else begin
                cand_pow_s = oPower;
                cand_idx_s = idx2_s;
            end
        end else if (oen && (oPower > pk_pow_r)) begin
            cand_pow_s = oPower;
            cand_idx_s = idx2_s;
        end else begin
            cand_pow_s = pk_pow_r;
            cand_idx_s = pk_idx_r;
        end
    end

    // Running peak state for the frame in progress.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            pk_pow_r <= '0;
            pk_idx_r <= '0;
        end else if (iclr) begin
            pk_pow_r <= '0;
            pk_idx_r <= '0;
        end else if (oen) begin
            pk_pow_r <= cand_pow_s;
            pk_idx_r <= cand_idx_s;
        end
    end

    // Frame result registers; an abandoned frame never pulses.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            oPeakVld <= 1'b0;
            oPeakIdx <= '0;
            oPeakPow <= '0;
        end else if (iclr) begin
            oPeakVld <= 1'b0;
        end else begin
            oPeakVld <= oen & oeop;
            if (oen && oeop) begin
                oPeakIdx <= cand_idx_s;
                oPeakPow <= cand_pow_s;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: expected bin powers and frame peaks are
// queued as samples are driven and popped as the design emits them.
module tb_fft_peak_detect;

    localparam int DW = 32'd16;
    localparam int ST = 32'd6;
    localparam int NB = 32'd64;

    logic        iclk = 1'b0;
    logic        rstn = 1'b1;
    logic        iclr = 1'b0;
    logic        ien  = 1'b0;
    logic [15:0] iReal = 16'd0;
    logic [15:0] iImag = 16'd0;
    logic [31:0] oPower;
    logic        oen;
    logic        osop;
    logic        oeop;
    logic [5:0]  oPeakIdx;
    logic [31:0] oPeakPow;
    logic        oPeakVld;

    typedef struct {
        longint pow;
        bit     sop;
        bit     eop;
    } bin_t;

    typedef struct {
        int     idx;
        longint pow;
    } pk_t;

    bin_t bin_q[$];
    pk_t  pk_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   oen_cnt = 0;
    int   pk_cnt  = 0;
    int   fr_re[NB];
    int   fr_im[NB];

    fft_peak_detect #(
        .DATA_WIDTH (DW),
        .FFT_STAGE  (ST),
        .SKIP_DC    (1)
    ) dut (
        .iclk     (iclk),
        .rstn     (rstn),
        .iclr     (iclr),
        .iReal    (iReal),
        .iImag    (iImag),
        .ien      (ien),
        .oPower   (oPower),
        .oen      (oen),
        .osop     (osop),
        .oeop     (oeop),
        .oPeakIdx (oPeakIdx),
        .oPeakPow (oPeakPow),
        .oPeakVld (oPeakVld)
    );

    always #5 iclk = ~iclk;

    always @(negedge iclk) begin
        bin_t e;
        pk_t  p;
        if (oen === 1'b1) begin
            oen_cnt++;
            checks++;
            if (bin_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_oen: got oPower=%0d with nothing expected", oPower);
            end else begin
                e = bin_q.pop_front();
                if ({oPower, osop, oeop} !== {32'(e.pow), e.sop, e.eop}) begin
                    errors++;
                    $display("FAIL bin_power: got pow=%0d sop=%0b eop=%0b, expected pow=%0d sop=%0b eop=%0b",
                             oPower, osop, oeop, e.pow, e.sop, e.eop);
                end
            end
        end
        if (oPeakVld === 1'b1) begin
            pk_cnt++;
            checks++;
            if (pk_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_peak: got idx=%0d pow=%0d with nothing expected", oPeakIdx, oPeakPow);
            end else begin
                p = pk_q.pop_front();
                if ({oPeakIdx, oPeakPow} !== {6'(p.idx), 32'(p.pow)}) begin
                    errors++;
                    $display("FAIL peak: got idx=%0d pow=%0d, expected idx=%0d pow=%0d",
                             oPeakIdx, oPeakPow, p.idx, p.pow);
                end
            end
        end
    end

    task automatic clear_frame();
        for (int k = 0; k < NB; k++) begin
            fr_re[k] = 0;
            fr_im[k] = 0;
        end
    endtask

    // Drives nbins samples of fr_re/fr_im; only the first push_lim are expected at oen.
    task automatic drive_frame(input int gap_pct, input int nbins, input bit clr_first, input int push_lim);
        int     b;
        longint p;
        longint best;
        int     bidx;
        bin_t   e;
        pk_t    pk;
        b = 0;
        while (b < nbins) begin
            @(posedge iclk);
            #1;
            if (b > 0 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                ien  = 1'b0;
                iclr = 1'b0;
            end else begin
                iclr  = (clr_first && b == 0) ? 1'b1 : 1'b0;
                ien   = 1'b1;
                iReal = 16'(fr_re[b]);
                iImag = 16'(fr_im[b]);
                if (b < push_lim) begin
                    e.pow = longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
                    e.sop = (b == 0);
                    e.eop = (b == NB - 1);
                    bin_q.push_back(e);
                end
                b++;
            end
        end
        if (nbins == NB && push_lim == NB) begin
            best = 0;
            bidx = 1;
            for (int k = 1; k < NB; k++) begin
                p = longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
                if (p > best) begin
                    best = p;
                    bidx = k;
                end
            end
            pk.idx = bidx;
            pk.pow = best;
            pk_q.push_back(pk);
        end
    endtask

    task automatic idle(input string name);
        int n;
        @(posedge iclk);
        #1;
        ien  = 1'b0;
        iclr = 1'b0;
        n = 0;
        while ((bin_q.size() != 0 || pk_q.size() != 0) && n < 40) begin
            @(posedge iclk);
            n++;
        end
        repeat (3) @(posedge iclk);
        #1;
        checks++;
        if (bin_q.size() != 0 || pk_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d bins and %0d peaks still outstanding, expected 0",
                     name, bin_q.size(), pk_q.size());
            bin_q.delete();
            pk_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({oPower, oen, osop, oeop, oPeakIdx, oPeakPow, oPeakVld} !== 73'd0) begin
            errors++;
            $display("FAIL %s: pow=%0d en=%0b sop=%0b eop=%0b pidx=%0d ppow=%0d pvld=%0b, expected all 0",
                     name, oPower, oen, osop, oeop, oPeakIdx, oPeakPow, oPeakVld);
        end
    endtask

    task automatic check_peak_held(input string name, input int pk0, input int exp_idx, input longint exp_pow);
        checks++;
        if (pk_cnt - pk0 != 1) begin
            errors++;
            $display("FAIL %s_pulses: got %0d oPeakVld pulses, expected 1", name, pk_cnt - pk0);
        end
        checks++;
        if ({oPeakIdx, oPeakPow} !== {6'(exp_idx), 32'(exp_pow)}) begin
            errors++;
            $display("FAIL %s_held: got idx=%0d pow=%0d, expected idx=%0d pow=%0d",
                     name, oPeakIdx, oPeakPow, exp_idx, exp_pow);
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        check_all_zero("reset_held");
        @(posedge iclk);
        #1 rstn = 1'b1;
        @(negedge iclk);
        check_all_zero("reset_release");
    endtask

    task automatic test_single_tone();
        int pk0;
        clear_frame();
        fr_re[5] = 1000;
        fr_im[5] = -2000;
        pk0 = pk_cnt;
        drive_frame(0, NB, 1'b0, NB);
        idle("single_tone");
        check_peak_held("single_tone", pk0, 5, 64'd5000000);
    endtask

    task automatic test_skip_dc();
        int pk0;
        clear_frame();
        fr_re[0] = 30000;
        fr_re[9] = 100;
        fr_im[9] = 100;
        pk0 = pk_cnt;
        drive_frame(0, NB, 1'b0, NB);
        idle("skip_dc");
        check_peak_held("skip_dc", pk0, 9, 64'd20000);
    endtask

    task automatic test_tie();
        int pk0;
        clear_frame();
        fr_re[3]  = 500;
        fr_im[3]  = 500;
        fr_re[40] = 500;
        fr_im[40] = 500;
        pk0 = pk_cnt;
        drive_frame(0, NB, 1'b0, NB);
        idle("tie");
        check_peak_held("tie", pk0, 3, 64'd500000);
    endtask

    task automatic test_max_neg();
        int pk0;
        clear_frame();
        fr_re[7] = -32768;
        fr_im[7] = -32768;
        pk0 = pk_cnt;
        drive_frame(0, NB, 1'b0, NB);
        idle("max_neg");
        check_peak_held("max_neg", pk0, 7, 64'd2147483648);
    endtask

    task automatic test_gaps();
        int o0;
        int pk0;
        for (int k = 0; k < NB; k++) begin
            fr_re[k] = int'($urandom_range(0, 65535)) - 32768;
            fr_im[k] = int'($urandom_range(0, 65535)) - 32768;
        end
        for (int pass = 0; pass < 2; pass++) begin
            o0  = oen_cnt;
            pk0 = pk_cnt;
            drive_frame(pass * 30, NB, 1'b0, NB);
            idle("gaps");
            checks++;
            if (oen_cnt - o0 != NB || pk_cnt - pk0 != 1) begin
                errors++;
                $display("FAIL gaps_count pass %0d: got %0d oen and %0d peaks, expected 64 and 1",
                         pass, oen_cnt - o0, pk_cnt - pk0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pk0;
        clear_frame();
        fr_re[12] = 7;
        pk0 = pk_cnt;
        drive_frame(0, NB, 1'b0, NB);
        fr_re[12] = 0;
        fr_im[63] = -9;
        drive_frame(0, NB, 1'b0, NB);
        idle("back_to_back");
        checks++;
        if (pk_cnt - pk0 != 2 || oPeakIdx !== 6'd63) begin
            errors++;
            $display("FAIL back_to_back: got %0d peaks idx=%0d, expected 2 peaks idx=63", pk_cnt - pk0, oPeakIdx);
        end
    endtask

    task automatic test_clear();
        int pk0;
        clear_frame();
        fr_re[2]  = 300;
        fr_re[25] = 1234;
        pk0 = pk_cnt;
        drive_frame(0, 20, 1'b0, 19);
        drive_frame(0, NB, 1'b1, NB);
        idle("clear");
        check_peak_held("clear", pk0, 25, 64'd1522756);
    endtask

    task automatic test_reset_mid();
        int pk0;
        clear_frame();
        fr_im[30] = 40;
        pk0 = pk_cnt;
        drive_frame(0, 20, 1'b0, 18);
        @(posedge iclk);
        #1;
        rstn = 1'b0;
        ien  = 1'b0;
        #1 check_all_zero("reset_mid_async");
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        check_all_zero("reset_mid_held");
        @(posedge iclk);
        #1 rstn = 1'b1;
        drive_frame(0, NB, 1'b0, NB);
        idle("reset_mid");
        check_peak_held("reset_mid", pk0, 30, 64'd1600);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_tone();
        test_skip_dc();
        test_tie();
        test_max_neg();
        test_gaps();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
